// File: rtl/seg_display_driver_if.sv
// Display-side bundle between the kitchen-timer block and seg_display_driver:
// BCD word, finish/ack controls, and the segment/anode/buzzer drive lines.
interface seg_display_driver_if;
  logic [15:0] digits;
  logic        finish;
  logic        ack;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        buzzer;

  modport master (output digits, finish, ack, input seg, dp, an, buzzer);
  modport slave  (input digits, finish, ack, output seg, dp, an, buzzer);
endinterface

// File: rtl/seg_display_driver.sv
// Four-digit multiplexed 7-segment driver with blink/buzzer alarm sequence.
// Optional macro SEG_LEADING_ZERO_BLANK_EN suppresses a leading tens-of-minutes zero.
module seg_display_driver #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLINK_DIV  = 250000,
  parameter int BLINKS     = 5,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  seg_display_driver_if.slave  disp
);

  localparam int SCAN_W  = (SCAN_DIV > 1)  ? $clog2(SCAN_DIV)  : 1;
  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int HALF_W  = $clog2(2 * BLINKS);

  localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [HALF_W-1:0]  HALF_LAST  = HALF_W'(2 * BLINKS - 1);

  localparam logic [6:0] SEG_INV = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [3:0] AN_INV  = (ACTIVE_LOW != 0) ? 4'hF  : 4'h0;
  localparam logic       DP_INV  = (ACTIVE_LOW != 0) ? 1'b1  : 1'b0;

  typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_ALARM = 1'b1} alarm_state_t;

  alarm_state_t       state_r, state_s;
  logic               phase_r, phase_s;
  logic [BLINK_W-1:0] blink_cnt_r, blink_cnt_s;
  logic [HALF_W-1:0]  half_cnt_r, half_cnt_s;
  logic [SCAN_W-1:0]  scan_cnt_r;
  logic [1:0]         idx_r;

  logic [3:0] nib_s;
  logic [3:0] an_act_s;
  logic       dp_act_s;
  logic [6:0] seg_r;
  logic       dp_r;
  logic [3:0] an_r;
  logic       buzzer_r;

  function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
    case (bcd)
      4'd0:    seg_decode = 7'h3F;
      4'd1:    seg_decode = 7'h06;
      4'd2:    seg_decode = 7'h5B;
      4'd3:    seg_decode = 7'h4F;
      4'd4:    seg_decode = 7'h66;
      4'd5:    seg_decode = 7'h6D;
      4'd6:    seg_decode = 7'h7D;
      4'd7:    seg_decode = 7'h07;
      4'd8:    seg_decode = 7'h7F;
      4'd9:    seg_decode = 7'h6F;
      default: seg_decode = 7'h40;
    endcase
  endfunction

  // Free-running digit scan; alarm activity never touches it.
  always_ff @(posedge clk) begin
    if (reset) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= 2'd0;
    end else if (scan_cnt_r == SCAN_LAST) begin
      scan_cnt_r <= {SCAN_W{1'b0}};
      idx_r      <= idx_r + 2'd1;
    end else begin
      scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
    end
  end

  // Alarm state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      phase_r     <= 1'b0;
      blink_cnt_r <= {BLINK_W{1'b0}};
      half_cnt_r  <= {HALF_W{1'b0}};
    end else begin
      state_r     <= state_s;
      phase_r     <= phase_s;
      blink_cnt_r <= blink_cnt_s;
      half_cnt_r  <= half_cnt_s;
    end
  end

  // Alarm next state: finish (re)starts the sequence and beats ack.
  always_comb begin
    state_s     = state_r;
    phase_s     = phase_r;
    blink_cnt_s = blink_cnt_r;
    half_cnt_s  = half_cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (disp.finish) begin
          state_s     = ST_ALARM;
          phase_s     = 1'b1;
          blink_cnt_s = {BLINK_W{1'b0}};
          half_cnt_s  = {HALF_W{1'b0}};
        end else begin
          state_s     = ST_IDLE;
        end
      end
      ST_ALARM: begin
        if (disp.finish) begin
          phase_s     = 1'b1;
          blink_cnt_s = {BLINK_W{1'b0}};
          half_cnt_s  = {HALF_W{1'b0}};
        end else if (disp.ack) begin
          state_s     = ST_IDLE;
          phase_s     = 1'b0;
          blink_cnt_s = {BLINK_W{1'b0}};
          half_cnt_s  = {HALF_W{1'b0}};
        end else if (blink_cnt_r == BLINK_LAST) begin
          blink_cnt_s = {BLINK_W{1'b0}};
          if (half_cnt_r == HALF_LAST) begin
            state_s    = ST_IDLE;
            phase_s    = 1'b0;
            half_cnt_s = {HALF_W{1'b0}};
          end else begin
            phase_s    = ~phase_r;
            half_cnt_s = half_cnt_r + HALF_W'(1);
          end
        end else begin
          blink_cnt_s = blink_cnt_r + BLINK_W'(1);
        end
      end
      default: begin
        state_s     = ST_IDLE;
        phase_s     = 1'b0;
        blink_cnt_s = {BLINK_W{1'b0}};
        half_cnt_s  = {HALF_W{1'b0}};
      end
    endcase
  end

  // Active-high view of the current slot; OFF phase blanks anodes and separator.
  always_comb begin
    nib_s    = 4'd0;
    an_act_s = 4'b0001 << idx_r;
    dp_act_s = (idx_r == 2'd2);
    case (idx_r)
      2'd0:    nib_s = disp.digits[3:0];
      2'd1:    nib_s = disp.digits[7:4];
      2'd2:    nib_s = disp.digits[11:8];
      2'd3:    nib_s = disp.digits[15:12];
      default: nib_s = 4'd0;
    endcase
    if ((state_r == ST_ALARM) && !phase_r) begin
      an_act_s = 4'b0000;
      dp_act_s = 1'b0;
    end else begin
`ifdef SEG_LEADING_ZERO_BLANK_EN
      if ((idx_r == 2'd3) && (disp.digits[15:12] == 4'd0)) begin
        an_act_s = 4'b0000;
      end else begin
        an_act_s = 4'b0001 << idx_r;
      end
`else
      an_act_s = 4'b0001 << idx_r;
`endif
    end
  end

  // Registered pin drive in board polarity.
  always_ff @(posedge clk) begin
    if (reset) begin
      seg_r    <= SEG_INV;
      dp_r     <= DP_INV;
      an_r     <= AN_INV;
      buzzer_r <= 1'b0;
    end else begin
      seg_r    <= seg_decode(nib_s) ^ SEG_INV;
      dp_r     <= dp_act_s ^ DP_INV;
      an_r     <= an_act_s ^ AN_INV;
      buzzer_r <= (state_r == ST_ALARM) && phase_r;
    end
  end

  assign disp.seg    = seg_r;
  assign disp.dp     = dp_r;
  assign disp.an     = an_r;
  assign disp.buzzer = buzzer_r;

endmodule

// File: tb/tb_seg_display_driver.sv
// Scoreboard bench for seg_display_driver: stimulus pushes expected pin values,
// a monitor pops and compares one entry after each rising edge.
module tb_seg_display_driver;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  seg_display_driver_if bus();

  seg_display_driver #(
    .SCAN_DIV  (4),
    .BLINK_DIV (8),
    .BLINKS    (2),
    .ACTIVE_LOW(1)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .disp (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       buz;
    string      tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   scan_n = 0;   // non-reset edges since the last reset
  int   alm    = -1;  // edges spent in the alarm, -1 when idle

  // Active-low segment patterns as they should appear on the pins.
  function automatic logic [6:0] pin_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    pin_seg = 7'h40;
      4'd1:    pin_seg = 7'h79;
      4'd2:    pin_seg = 7'h24;
      4'd3:    pin_seg = 7'h30;
      4'd4:    pin_seg = 7'h19;
      4'd5:    pin_seg = 7'h12;
      4'd6:    pin_seg = 7'h02;
      4'd7:    pin_seg = 7'h78;
      4'd8:    pin_seg = 7'h00;
      4'd9:    pin_seg = 7'h10;
      default: pin_seg = 7'h3F;
    endcase
  endfunction

  task automatic tick(input logic rst, input logic fin, input logic ak,
                      input logic [15:0] dig, input string tag);
    exp_t       e;
    int         slot;
    logic [3:0] nib;
    @(negedge clk);
    reset       = rst;
    bus.finish  = fin;
    bus.ack     = ak;
    bus.digits  = dig;
    if (rst) begin
      e.seg = 7'h7F; e.dp = 1'b1; e.an = 4'hF; e.buz = 1'b0;
    end else begin
      slot  = (scan_n / 4) % 4;
      nib   = dig[slot*4 +: 4];
      e.seg = pin_seg(nib);
      if (alm >= 0 && ((alm / 8) % 2) == 1) begin
        e.an = 4'hF; e.dp = 1'b1; e.buz = 1'b0;
      end else begin
        e.an       = 4'hF;
        e.an[slot] = 1'b0;
        e.dp       = (slot == 2) ? 1'b0 : 1'b1;
        e.buz      = (alm >= 0);
`ifdef SEG_LEADING_ZERO_BLANK_EN
        if (slot == 3 && dig[15:12] == 4'd0) e.an = 4'hF;
`endif
      end
    end
    e.tag = tag;
    sb_q.push_back(e);
    if (rst) begin
      scan_n = 0;
      alm    = -1;
    end else begin
      scan_n = scan_n + 1;
      if (fin) alm = 0;
      else if (alm >= 0 && ak) alm = -1;
      else if (alm >= 0) begin
        alm = alm + 1;
        if (alm == 32) alm = -1;
      end
    end
  endtask

  // Monitor: compare the pins against the oldest expectation after each edge.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() > 0) begin
      mon_e = sb_q.pop_front();
      n_cmp = n_cmp + 1;
      if (bus.seg !== mon_e.seg || bus.dp !== mon_e.dp ||
          bus.an !== mon_e.an || bus.buzzer !== mon_e.buz) begin
        n_bad = n_bad + 1;
        $display("FAIL %0s t=%0t got seg=%h dp=%b an=%b buz=%b want seg=%h dp=%b an=%b buz=%b",
                 mon_e.tag, $time, bus.seg, bus.dp, bus.an, bus.buzzer,
                 mon_e.seg, mon_e.dp, mon_e.an, mon_e.buz);
      end
    end
  end

  initial begin
    bus.digits = 16'h1234;
    bus.finish = 1'b0;
    bus.ack    = 1'b0;

    repeat (2)  tick(1'b1, 1'b0, 1'b0, 16'h1234, "reset");
    repeat (32) tick(1'b0, 1'b0, 1'b0, 16'h1234, "scan1234");
    repeat (16) tick(1'b0, 1'b0, 1'b0, 16'h6789, "scan6789");
    repeat (16) tick(1'b0, 1'b0, 1'b0, 16'h12AB, "badbcd");

    tick(1'b0, 1'b1, 1'b0, 16'h1234, "finish");
    repeat (40) tick(1'b0, 1'b0, 1'b0, 16'h1234, "autostop");

    tick(1'b0, 1'b1, 1'b0, 16'h1234, "finish");
    repeat (3)  tick(1'b0, 1'b0, 1'b0, 16'h1234, "alarm_on");
    tick(1'b0, 1'b0, 1'b1, 16'h1234, "ack");
    repeat (16) tick(1'b0, 1'b0, 1'b0, 16'h1234, "resume");

    tick(1'b0, 1'b1, 1'b0, 16'h1234, "finish");
    repeat (5)  tick(1'b0, 1'b0, 1'b0, 16'h1234, "alarm_on");
    tick(1'b0, 1'b1, 1'b1, 16'h1234, "fin_ack");
    repeat (20) tick(1'b0, 1'b0, 1'b0, 16'h1234, "restart");

    tick(1'b0, 1'b1, 1'b0, 16'h1234, "finish");
    repeat (10) tick(1'b0, 1'b0, 1'b0, 16'h1234, "to_off");
    tick(1'b1, 1'b0, 1'b0, 16'h1234, "rst_mid");
    repeat (12) tick(1'b0, 1'b0, 1'b0, 16'h1234, "post_rst");

`ifdef SEG_LEADING_ZERO_BLANK_EN
    repeat (16) tick(1'b0, 1'b0, 1'b0, 16'h0530, "lz_0530");
    repeat (16) tick(1'b0, 1'b0, 1'b0, 16'h1530, "lz_1530");
`else
    repeat (16) tick(1'b0, 1'b0, 1'b0, 16'h0530, "zero0530");
`endif

    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_cmp = n_cmp + 1;
      n_bad = n_bad + 1;
      $display("FAIL drain pending=%0d want 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
